// File: rtl/riscv_wb_buffer_pkg.sv
// rtl/riscv_wb_buffer_pkg.sv - shared types and constants for the write-back buffer
package riscv_wb_pkg;

    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] WB_ADDR_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic                  kill;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic int WB_CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/riscv_wb_buffer_if.sv
// rtl/riscv_wb_buffer_if.sv - producer, register-file and status signals of the write-back buffer
interface riscv_wb_buffer_if
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = WB_CNT_W(DEPTH);

    logic                       alu_we_i;
    logic [ADDR_WIDTH-1:0]      alu_waddr_i;
    logic [DATA_WIDTH-1:0]      alu_wdata_i;
    logic                       lsu_valid_i;
    logic                       lsu_ready_o;
    logic [ADDR_WIDTH-1:0]      lsu_waddr_i;
    logic [DATA_WIDTH-1:0]      lsu_wdata_i;
    logic                       md_valid_i;
    logic                       md_ready_o;
    logic [ADDR_WIDTH-1:0]      md_waddr_i;
    logic [DATA_WIDTH-1:0]      md_wdata_i;
    logic                       we_a_o;
    logic [ADDR_WIDTH-1:0]      waddr_a_o;
    logic [DATA_WIDTH-1:0]      wdata_a_o;
    logic                       we_b_o;
    logic [ADDR_WIDTH-1:0]      waddr_b_o;
    logic [DATA_WIDTH-1:0]      wdata_b_o;
    logic [2**ADDR_WIDTH-1:0]   busy_o;
    logic [CW-1:0]              fifo_cnt_o;

    modport slave (
        input  alu_we_i, alu_waddr_i, alu_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  md_valid_i, md_waddr_i, md_wdata_i,
        output lsu_ready_o, md_ready_o,
        output we_a_o, waddr_a_o, wdata_a_o,
        output we_b_o, waddr_b_o, wdata_b_o,
        output busy_o, fifo_cnt_o
    );

    modport master (
        output alu_we_i, alu_waddr_i, alu_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output md_valid_i, md_waddr_i, md_wdata_i,
        input  lsu_ready_o, md_ready_o,
        input  we_a_o, waddr_a_o, wdata_a_o,
        input  we_b_o, waddr_b_o, wdata_b_o,
        input  busy_o, fifo_cnt_o
    );

endinterface

// File: rtl/riscv_wb_buffer_fifo.sv
// rtl/riscv_wb_buffer_fifo.sv - 2-push/1-pop in-order result FIFO with WAW kill compare
module riscv_wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = WB_CNT_W(DEPTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push0,
    input  wb_entry_t             push0_entry,
    input  logic                  push1,
    input  wb_entry_t             push1_entry,
    input  logic                  pop,
    input  logic                  kill_en,
    input  logic [ADDR_WIDTH-1:0] kill_addr,
    output wb_entry_t             head,
    output logic [DEPTH-1:0]      live,
    output logic [ADDR_WIDTH-1:0] live_addr [DEPTH],
    output logic [CW-1:0]         cnt
);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;

    assign head = mem[rptr];

    // Entries that will still write the RF (for the busy scoreboard)
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live[i]      = mem[i].valid && !mem[i].kill && (mem[i].addr != WB_ADDR_ZERO);
            live_addr[i] = mem[i].addr;
        end
    end

    // Kill matching entries, retire the head, append up to two new entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (kill_en && mem[i].valid && (mem[i].addr == kill_addr))
                    mem[i].kill <= 1'b1;
            if (pop) begin
                mem[rptr].valid <= 1'b0;
                rptr            <= rptr + PW'(1);
            end
            if (push0) mem[wptr] <= push0_entry;
            if (push1) mem[wptr + PW'(1)] <= push1_entry;
            wptr <= wptr + PW'(push0) + PW'(push1);
            cnt  <= cnt + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

endmodule

// File: rtl/riscv_wb_buffer.sv
// rtl/riscv_wb_buffer.sv - write-back staging for RF ports A/B, optional WB_BYPASS_EN shortcut
module riscv_wb_buffer
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    riscv_wb_buffer_if.slave bus
);

    localparam int CW = WB_CNT_W(DEPTH);

    logic [CW-1:0]            cnt;
    wb_entry_t                head;
    logic [DEPTH-1:0]         live;
    logic [ADDR_WIDTH-1:0]    live_addr [DEPTH];
    logic                     lsu_xfer, md_xfer, bypass, pop, push0, push1, head_kill;
    wb_entry_t                lsu_e, md_e, first_e, push0_e;
    logic [2**ADDR_WIDTH-1:0] busy;

    // Readies look only at the pre-pop count, so a pop never makes room this cycle
    assign bus.lsu_ready_o = cnt < CW'(DEPTH);
    assign bus.md_ready_o  = (cnt <= CW'(DEPTH - 2)) ||
                             ((cnt == CW'(DEPTH - 1)) && !bus.lsu_valid_i);
    assign lsu_xfer = bus.lsu_valid_i && bus.lsu_ready_o;
    assign md_xfer  = bus.md_valid_i && bus.md_ready_o;
    assign pop      = cnt != '0;
    assign head_kill = head.kill || (bus.alu_we_i && (head.addr == bus.alu_waddr_i));

    // Tag arrivals with this cycle's ALU kill; LSU is older than MD when both arrive
    always_comb begin
        lsu_e   = '{valid: 1'b1,
                    kill:  bus.alu_we_i && (bus.lsu_waddr_i == bus.alu_waddr_i),
                    addr:  bus.lsu_waddr_i, data: bus.lsu_wdata_i};
        md_e    = '{valid: 1'b1,
                    kill:  bus.alu_we_i && (bus.md_waddr_i == bus.alu_waddr_i),
                    addr:  bus.md_waddr_i, data: bus.md_wdata_i};
        first_e = lsu_xfer ? lsu_e : md_e;
`ifdef WB_BYPASS_EN
        bypass  = (cnt == '0) && (lsu_xfer || md_xfer);
`else
        bypass  = 1'b0;
`endif
        push0   = bypass ? (lsu_xfer && md_xfer) : (lsu_xfer || md_xfer);
        push0_e = bypass ? md_e : first_e;
        push1   = !bypass && lsu_xfer && md_xfer;
    end

    riscv_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (push0),
        .push0_entry (push0_e),
        .push1       (push1),
        .push1_entry (md_e),
        .pop         (pop),
        .kill_en     (bus.alu_we_i),
        .kill_addr   (bus.alu_waddr_i),
        .head        (head),
        .live        (live),
        .live_addr   (live_addr),
        .cnt         (cnt)
    );

    // Port A: ALU result one cycle later, x0 suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.we_a_o    <= 1'b0;
            bus.waddr_a_o <= '0;
            bus.wdata_a_o <= '0;
        end else begin
            bus.we_a_o    <= bus.alu_we_i && (bus.alu_waddr_i != WB_ADDR_ZERO);
            bus.waddr_a_o <= bus.alu_waddr_i;
            bus.wdata_a_o <= bus.alu_wdata_i;
        end
    end

    // Port B: FIFO head (or a bypassed arrival); killed and x0 entries drain silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.we_b_o    <= 1'b0;
            bus.waddr_b_o <= '0;
            bus.wdata_b_o <= '0;
        end else if (pop) begin
            bus.we_b_o    <= head.valid && !head_kill && (head.addr != WB_ADDR_ZERO);
            bus.waddr_b_o <= head.addr;
            bus.wdata_b_o <= head.data;
        end else if (bypass) begin
            bus.we_b_o    <= first_e.valid && !first_e.kill && (first_e.addr != WB_ADDR_ZERO);
            bus.waddr_b_o <= first_e.addr;
            bus.wdata_b_o <= first_e.data;
        end else begin
            bus.we_b_o    <= 1'b0;
        end
    end

    // Busy scoreboard: queued live entries plus the pending port B write
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (live[i]) busy[live_addr[i]] = 1'b1;
        if (bus.we_b_o) busy[bus.waddr_b_o] = 1'b1;
    end

    assign bus.busy_o     = busy;
    assign bus.fifo_cnt_o = cnt;

endmodule
